// File: rtl/branch_cmp_unit.sv
// Branch-condition resolver: evaluates one of eight conditions on two operands
// behind a valid/ready handshake, with saturating delivery statistics.
module branch_cmp_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] d1,
    input  logic [WIDTH-1:0] d2,
    input  logic [2:0]       mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             taken,
    output logic             eq,
    input  logic             clr_cnt,
    output logic [CNT_W-1:0] total_cnt,
    output logic [CNT_W-1:0] taken_cnt,
    output logic             cnt_sat
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    typedef enum logic [2:0] {
        C_EQ  = 3'd0,
        C_NE  = 3'd1,
        C_LEZ = 3'd2,
        C_GTZ = 3'd3,
        C_LTZ = 3'd4,
        C_GEZ = 3'd5,
        C_LT  = 3'd6,
        C_LTU = 3'd7
    } cond_e;

    logic             accept;
    logic             deliver;
    logic             ops_eq;
    logic             d1_neg;
    logic             d1_zero;
    logic             cond;
    logic [CNT_W-1:0] total_nxt;
    logic [CNT_W-1:0] taken_nxt;

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;
    assign deliver  = out_valid && out_ready;

    assign ops_eq  = (d1 == d2);
    assign d1_neg  = d1[WIDTH-1];
    assign d1_zero = (d1 == '0);

    always_comb begin
        cond = 1'b0;
        unique case (cond_e'(mode))
            C_EQ:  cond = ops_eq;
            C_NE:  cond = !ops_eq;
            C_LEZ: cond = d1_neg || d1_zero;
            C_GTZ: cond = !d1_neg && !d1_zero;
            C_LTZ: cond = d1_neg;
            C_GEZ: cond = !d1_neg;
            C_LT:  cond = ($signed(d1) < $signed(d2));
            C_LTU: cond = (d1 < d2);
            default: cond = 1'b0;
        endcase
    end

    // taken/eq only load on accept so they stay stable under backpressure
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid <= 1'b0;
            taken     <= 1'b0;
            eq        <= 1'b0;
        end else if (accept) begin
            out_valid <= 1'b1;
            taken     <= cond;
            eq        <= ops_eq;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // counters use the result leaving the register, not the one entering
    always_comb begin
        total_nxt = total_cnt;
        taken_nxt = taken_cnt;
        if (deliver) begin
            if (total_cnt != CNT_MAX) total_nxt = total_cnt + 1'b1;
            if (taken && taken_cnt != CNT_MAX) taken_nxt = taken_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            total_cnt <= '0;
            taken_cnt <= '0;
            cnt_sat   <= 1'b0;
        end else if (clr_cnt) begin
            total_cnt <= '0;
            taken_cnt <= '0;
            cnt_sat   <= 1'b0;
        end else begin
            total_cnt <= total_nxt;
            taken_cnt <= taken_nxt;
            cnt_sat   <= cnt_sat || (total_nxt == CNT_MAX) || (taken_nxt == CNT_MAX);
        end
    end

endmodule

// File: tb/tb_branch_cmp_unit.sv
// Directed bench for branch_cmp_unit: default instance plus a CNT_W=2
// instance for saturation behaviour.
module tb_branch_cmp_unit;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        in_valid, out_ready, clr_cnt;
    logic [31:0] d1, d2;
    logic [2:0]  mode;
    logic        in_ready, out_valid, taken, eq, cnt_sat;
    logic [15:0] total_cnt, taken_cnt;

    logic        in_valid2, out_ready2, clr_cnt2;
    logic        in_ready2, out_valid2, taken2, eq2, cnt_sat2;
    logic [1:0]  total_cnt2, taken_cnt2;

    int n_checks = 0;
    int n_fails  = 0;

    always #5 clk = ~clk;

    branch_cmp_unit #(.WIDTH(32), .CNT_W(16)) dut (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
        .d1(d1), .d2(d2), .mode(mode), .out_valid(out_valid), .out_ready(out_ready),
        .taken(taken), .eq(eq), .clr_cnt(clr_cnt), .total_cnt(total_cnt),
        .taken_cnt(taken_cnt), .cnt_sat(cnt_sat)
    );

    branch_cmp_unit #(.WIDTH(32), .CNT_W(2)) dut_sat (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid2), .in_ready(in_ready2),
        .d1(d1), .d2(d2), .mode(mode), .out_valid(out_valid2), .out_ready(out_ready2),
        .taken(taken2), .eq(eq2), .clr_cnt(clr_cnt2), .total_cnt(total_cnt2),
        .taken_cnt(taken_cnt2), .cnt_sat(cnt_sat2)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [7:0] exp_neg;
    logic [7:0] exp_zero;

    initial begin
        exp_neg  = 8'b0101_0110;
        exp_zero = 8'b0010_0101;
        reset_n = 1'b0; in_valid = 1'b1; out_ready = 1'b0; clr_cnt = 1'b0;
        in_valid2 = 1'b0; out_ready2 = 1'b0; clr_cnt2 = 1'b0;
        d1 = '0; d2 = '0; mode = '0;

        // reset with a request pending
        step(); step();
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_taken", taken, 0);
        check("rst_eq", eq, 0);
        check("rst_total", total_cnt, 0);
        check("rst_taken_cnt", taken_cnt, 0);
        check("rst_sat", cnt_sat, 0);
        in_valid = 1'b0;
        reset_n = 1'b1;
        step(); step();
        check("idle_out_valid", out_valid, 0);

        // mode sweep
        out_ready = 1'b1;
        in_valid = 1'b1;
        d1 = 32'hFFFF_FFFF; d2 = 32'h0000_0001;
        for (int m = 0; m < 8; m++) begin
            mode = 3'(m);
            step();
            check($sformatf("neg_taken_m%0d", m), taken, exp_neg[m]);
            check($sformatf("neg_eq_m%0d", m), eq, 0);
        end
        d1 = '0; d2 = '0;
        for (int m = 0; m < 8; m++) begin
            mode = 3'(m);
            step();
            check($sformatf("zero_taken_m%0d", m), taken, exp_zero[m]);
            check($sformatf("zero_eq_m%0d", m), eq, 1);
        end
        in_valid = 1'b0;
        step();
        check("sweep_total", total_cnt, 16);
        check("sweep_taken_cnt", taken_cnt, 7);
        check("sweep_out_valid", out_valid, 0);
        clr_cnt = 1'b1; step(); clr_cnt = 1'b0;
        check("clr_total", total_cnt, 0);

        // backpressure
        in_valid = 1'b1; mode = 3'd0; d1 = 32'd5; d2 = 32'd5;
        step();
        out_ready = 1'b0;
        mode = 3'd1; d1 = 32'd1; d2 = 32'd2;
        #1;
        check("bp_in_ready", in_ready, 0);
        for (int i = 0; i < 3; i++) begin
            step();
            check("bp_valid", out_valid, 1);
            check("bp_taken", taken, 1);
            check("bp_eq", eq, 1);
            check("bp_in_ready_hold", in_ready, 0);
            check("bp_total", total_cnt, 0);
        end
        out_ready = 1'b1;
        #1;
        check("bp_release_ready", in_ready, 1);
        step();
        in_valid = 1'b0;
        check("bp_b_taken", taken, 1);
        check("bp_b_eq", eq, 0);
        check("bp_total_one", total_cnt, 1);
        step();
        check("bp_total_two", total_cnt, 2);
        clr_cnt = 1'b1; step(); clr_cnt = 1'b0;

        // full-rate NE stream alternating true/false
        mode = 3'd1; in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            d1 = 32'(100 + i);
            d2 = (i % 2 == 0) ? 32'(101 + i) : 32'(100 + i);
            step();
            check("stream_valid", out_valid, 1);
            check($sformatf("stream_taken_%0d", i), taken, (i % 2 == 0) ? 1 : 0);
        end
        in_valid = 1'b0;
        step();
        check("stream_total", total_cnt, 10);
        check("stream_taken_cnt", taken_cnt, 5);

        // async reset while stalled
        in_valid = 1'b1; out_ready = 1'b0; mode = 3'd0; d1 = 32'd3; d2 = 32'd3;
        step();
        in_valid = 1'b0;
        check("ar_pre_valid", out_valid, 1);
        #2 reset_n = 1'b0;
        #1;
        check("ar_out_valid", out_valid, 0);
        check("ar_total", total_cnt, 0);
        check("ar_taken_cnt", taken_cnt, 0);
        check("ar_in_ready", in_ready, 1);
        step();
        reset_n = 1'b1;
        out_ready = 1'b1;
        step();

        // saturation on the 2-bit counter instance
        mode = 3'd0; d1 = 32'd7; d2 = 32'd7;
        in_valid2 = 1'b1; out_ready2 = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            if (i == 2) begin
                check("sat_mid_total", total_cnt2, 2);
                check("sat_mid_flag", cnt_sat2, 0);
            end
        end
        check("sat_total", total_cnt2, 3);
        check("sat_taken_cnt", taken_cnt2, 3);
        check("sat_flag", cnt_sat2, 1);
        check("sat_valid_pending", out_valid2, 1);
        in_valid2 = 1'b0; clr_cnt2 = 1'b1;
        step();
        clr_cnt2 = 1'b0;
        check("sat_clr_total", total_cnt2, 0);
        check("sat_clr_taken_cnt", taken_cnt2, 0);
        check("sat_clr_flag", cnt_sat2, 0);
        check("sat_clr_delivered", out_valid2, 0);
        step();
        check("sat_after_total", total_cnt2, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/branch_cmp_unit.md
# branch_cmp_unit

Parametrised branch-condition resolver for the pipelined MIPS core, the successor to the single-mode equality comparator. It takes two operands and a 3-bit condition code through a valid/ready handshake, evaluates one of eight signed/unsigned conditions, and returns a registered taken/not-taken result one cycle later. It also keeps saturating statistics counters of resolved and taken branches for the performance monitor.

## Interface
- WIDTH, 32, operand width in bits (>= 2)
- CNT_W, 16, width of each statistics counter (>= 2)

- clk  input  1  rising-edge clock
- reset_n  input  1  asynchronous active-low reset
- in_valid  input  1  operands/mode present
- in_ready  output  1  unit can accept a request this cycle
- d1  input  WIDTH  first operand (rs)
- d2  input  WIDTH  second operand (rt); ignored by zero-compare modes
- mode  input  3  condition code (see Operation)
- out_valid  output  1  registered result present
- out_ready  input  1  consumer takes the result this cycle
- taken  output  1  condition true for the held result
- eq  output  1  d1 == d2 for the held result, independent of mode
- clr_cnt  input  1  synchronous clear of counters and cnt_sat
- total_cnt  output  CNT_W  number of results delivered
- taken_cnt  output  CNT_W  number of delivered results with taken = 1
- cnt_sat  output  1  sticky: a counter has hit all-ones

## Operation
- Conditions by mode:
  - 0 EQ: d1 == d2
  - 1 NE: d1 != d2
  - 2 LEZ: d1 <= 0 (signed)
  - 3 GTZ: d1 > 0 (signed)
  - 4 LTZ: d1 < 0, i.e. d1 MSB = 1
  - 5 GEZ: d1 >= 0
  - 6 LT: d1 < d2 (signed)
  - 7 LTU: d1 < d2 (unsigned)
- Signed comparisons use WIDTH-bit two's complement. No width extension of inputs is performed.
- Output stage: one register holding taken, eq and out_valid.
- Accept condition: in_valid && in_ready. The result of an accepted request is loaded into the output register at the same clock edge.
- in_ready = !out_valid || out_ready. This is combinational, so back-to-back requests flow at full rate. No combinational path runs from in_valid to out_valid.
- Stall behaviour: while out_valid && !out_ready, the output register, taken and eq hold stable, and in_ready = 0.
- Counting occurs on the output handshake out_valid && out_ready:
  - total_cnt += 1
  - taken_cnt += 1 if taken
- Saturation: each counter sticks at all-ones and never wraps. cnt_sat is set when either counter reaches all-ones, and stays set until clr_cnt or reset.
- clr_cnt priority: clr_cnt clears both counters and cnt_sat. It takes priority over a coincident handshake; that delivery is not counted. The data path is unaffected by clr_cnt.

## Timing
- Reset (reset_n low, asynchronous): out_valid = 0, taken = 0, eq = 0, total_cnt = 0, taken_cnt = 0, cnt_sat = 0. in_ready is therefore 1 during and after reset.
- Reset mid-operation drops any held result. It is not counted.
- Latency: request accepted at edge N gives out_valid = 1 with its result visible after edge N.
- Throughput: one result per cycle while out_ready = 1.
- Simultaneous events: handshake-out and accept-in in the same cycle replace the register with the new result. The counter update uses the old result.
- Counter outputs are registered and reflect handshakes up to the previous edge.

## Test plan
- Reset then idle: hold reset_n = 0 and drive in_valid = 1 -> out_valid = 0, counters = 0, in_ready = 1. After release, no result appears until accept.
- Mode sweep, WIDTH = 32, out_ready = 1: d1 = 0xFFFFFFFF, d2 = 0x00000001 -> per mode 0..7 taken = 0,1,1,0,1,0,1,0. d1 = d2 = 0 -> taken = 1,0,1,0,0,1,0,0, with eq = 1 throughout.
- Backpressure: accept req A (EQ, 5 vs 5), then out_ready = 0 for 3 cycles with req B pending -> taken/eq stay 1, in_ready = 0, B is not accepted. Raise out_ready -> B is accepted in the same cycle, total_cnt = 1.
- Full-rate stream: 10 consecutive requests, alternate NE true/false, out_ready = 1 -> 10 results on consecutive cycles, total_cnt = 10, taken_cnt = 5.
- Saturation with CNT_W = 2: 5 taken deliveries -> counters stop at 3, cnt_sat = 1. Then clr_cnt coincident with a handshake -> counters = 0, cnt_sat = 0.
- Async reset while out_valid = 1 and stalled -> out_valid falls immediately, before the next edge, and counters are 0.
